vga_text_console: RTL and testbench



---
 rtl/vga_pkg.sv | 43 ++++
 rtl/vga_text_console_if.sv | 25 ++
 rtl/vga_console_cursor.sv | 60 ++++++
 rtl/vga_text_console.sv | 260 ++++++++++++++++++++++++++
 tb/tb_vga_text_console.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared constants and encodings for the VGA text console: screen geometry,
// ASCII control codes, FSM states and cursor commands.
package vga_pkg;

    localparam int                VGA_COLS     = 80;
    localparam int                VGA_ROWS     = 30;
    localparam logic [12:0]       VGA_BUF_BASE = 13'h1000;

    localparam int COL_W = 7;
    localparam int ROW_W = 5;
    localparam int IDX_W = 12;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_SCROLL_RD,
        ST_SCROLL_WAIT,
        ST_SCROLL_WR,
        ST_SCROLL_CLR,
        ST_CLEAR
    } state_e;

    typedef enum logic [2:0] {
        CUR_NONE,
        CUR_ADVANCE,
        CUR_CR,
        CUR_NEWLINE,
        CUR_BACK,
        CUR_HOME,
        CUR_LAST_ROW
    } cursor_cmd_e;

    function automatic logic is_printable(input logic [7:0] c);
        return c >= CH_SPACE;
    endfunction

endpackage

// File: rtl/vga_text_console_if.sv
// Register-bus connection between the text console (master) and vga_top (slave).
interface vga_text_console_if #(
    parameter int C_AXI_ADDR_WIDTH = 13,
    parameter int C_AXI_DATA_WIDTH = 32
);
    logic [C_AXI_DATA_WIDTH-1:0] axil_wdata_o;
    logic [3:0]                  axil_wstrb_o;
    logic [C_AXI_ADDR_WIDTH-1:0] axil_waddr_o;
    logic                        axil_wready_o;
    logic                        axil_rreq_o;
    logic [C_AXI_ADDR_WIDTH-1:0] axil_raddr_o;
    logic [C_AXI_DATA_WIDTH-1:0] axil_rdata_i;

    modport master (
        output axil_wdata_o, axil_wstrb_o, axil_waddr_o, axil_wready_o,
        output axil_rreq_o, axil_raddr_o,
        input  axil_rdata_i
    );

    modport slave (
        input  axil_wdata_o, axil_wstrb_o, axil_waddr_o, axil_wready_o,
        input  axil_rreq_o, axil_raddr_o,
        output axil_rdata_i
    );
endinterface

// File: rtl/vga_console_cursor.sv
// Text cursor: row/column counters driven by one command per cycle, plus the
// linear tile index and end-of-screen flags derived from them.
module vga_console_cursor
    import vga_pkg::*;
#(
    parameter int COLS = VGA_COLS,
    parameter int ROWS = VGA_ROWS
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  cursor_cmd_e       cmd,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic [IDX_W-1:0]  tile_idx,
    output logic              last_tile,
    output logic              last_row
);

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col <= '0;
            row <= '0;
        end else begin
            case (cmd)
                CUR_ADVANCE: begin
                    // Row saturates at the bottom; the console scrolls instead.
                    if (col == COL_MAX) begin
                        col <= '0;
                        if (row != ROW_MAX) row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                CUR_CR:      col <= '0;
                CUR_NEWLINE: begin
                    col <= '0;
                    if (row != ROW_MAX) row <= row + 1'b1;
                end
                CUR_BACK:    if (col != '0) col <= col - 1'b1;
                CUR_HOME: begin
                    col <= '0;
                    row <= '0;
                end
                CUR_LAST_ROW: begin
                    col <= '0;
                    row <= ROW_MAX;
                end
                default: ;
            endcase
        end
    end

    assign tile_idx  = IDX_W'(row) * IDX_W'(COLS) + IDX_W'(col);
    assign last_row  = (row == ROW_MAX);
    assign last_tile = last_row && (col == COL_MAX);

endmodule

// File: rtl/vga_text_console.sv
// Byte-stream to text-buffer writer for vga_top: cursor handling, clear screen
// and scroll-up by copying each tile one row up through the read port.
module vga_text_console
    import vga_pkg::*;
#(
    parameter int                          C_AXI_ADDR_WIDTH = 13,
    parameter int                          C_AXI_DATA_WIDTH = 32,
    parameter int                          COLS             = VGA_COLS,
    parameter int                          ROWS             = VGA_ROWS,
    parameter logic [C_AXI_ADDR_WIDTH-1:0] BUF_BASE         = VGA_BUF_BASE,
    parameter int                          RD_LAT           = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [7:0]           char_i,
    input  logic                 char_valid_i,
    output logic                 char_ready_o,
    vga_text_console_if.master   bus,
    output logic [COL_W-1:0]     cursor_col_o,
    output logic [ROW_W-1:0]     cursor_row_o,
    output logic                 busy_o
);

    localparam int AW         = C_AXI_ADDR_WIDTH;
    localparam int COPY_LAST  = COLS * (ROWS - 1) - 1;
    localparam int CLEAR_LAST = COLS * ROWS - 1;
    localparam int WAIT_W     = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
    localparam logic [AW-1:0] LAST_ROW_BASE = BUF_BASE + AW'(COLS * (ROWS - 1));

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic                 pend_q, pend_d;
    logic                 started_q;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 wready_q, wready_d;
    logic                 rreq_q, rreq_d;
    logic                 copy_q, copy_d;
    logic [AW-1:0]        waddr_q, waddr_d;
    logic [AW-1:0]        raddr_q, raddr_d;
    logic [7:0]           wbyte_q, wbyte_d;
    logic [3:0]           wstrb_q;
    logic                 start_scroll, start_copy_wr;

    cursor_cmd_e          cur_cmd;
    logic [COL_W-1:0]     cur_col;
    logic [ROW_W-1:0]     cur_row;
    logic [IDX_W-1:0]     cur_tile;
    logic                 cur_last_tile, cur_last_row;

    logic                 accept;
    logic                 unused_rdata;

    vga_console_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .cmd       (cur_cmd),
        .col       (cur_col),
        .row       (cur_row),
        .tile_idx  (cur_tile),
        .last_tile (cur_last_tile),
        .last_row  (cur_last_row)
    );

    assign accept = char_valid_i && ready_q;

    // Bus outputs are computed for the state being entered and registered at
    // the same edge, so each strobe lines up with its state's cycle.
    always_comb begin
        // NOTE: every value written here gets a default first, so no path leaves a latch.
        state_d       = state_q;
        idx_d         = idx_q;
        wait_d        = wait_q;
        pend_d        = pend_q;
        wready_d      = 1'b0;
        rreq_d        = 1'b0;
        copy_d        = 1'b0;
        waddr_d       = waddr_q;
        raddr_d       = raddr_q;
        wbyte_d       = wbyte_q;
        cur_cmd       = CUR_NONE;
        start_scroll  = 1'b0;
        start_copy_wr = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_printable(char_i)) begin
                        cur_cmd  = CUR_ADVANCE;
                        pend_d   = cur_last_tile;
                        state_d  = ST_WRITE;
                        wready_d = 1'b1;
                        waddr_d  = BUF_BASE + AW'(cur_tile);
                        wbyte_d  = char_i;
                    end else begin
                        case (char_i)
                            CH_CR: cur_cmd = CUR_CR;
                            CH_LF: begin
                                if (cur_last_row) begin
                                    cur_cmd      = CUR_CR;
                                    start_scroll = 1'b1;
                                end else begin
                                    cur_cmd = CUR_NEWLINE;
                                end
                            end
                            CH_BS: begin
                                if (cur_col != '0) begin
                                    cur_cmd  = CUR_BACK;
                                    pend_d   = 1'b0;
                                    state_d  = ST_WRITE;
                                    wready_d = 1'b1;
                                    waddr_d  = BUF_BASE + AW'(cur_tile) - 1'b1;
                                    wbyte_d  = CH_SPACE;
                                end
                            end
                            CH_FF: begin
                                cur_cmd  = CUR_HOME;
                                state_d  = ST_CLEAR;
                                idx_d    = '0;
                                wready_d = 1'b1;
                                waddr_d  = BUF_BASE;
                                wbyte_d  = CH_SPACE;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            ST_WRITE: begin
                if (pend_q) start_scroll = 1'b1;
                else        state_d      = ST_IDLE;
            end

            ST_SCROLL_RD: begin
                if (RD_LAT == 1) begin
                    start_copy_wr = 1'b1;
                end else begin
                    state_d = ST_SCROLL_WAIT;
                    wait_d  = '0;
                end
            end

            ST_SCROLL_WAIT: begin
                if (wait_q == WAIT_W'(RD_LAT - 2)) start_copy_wr = 1'b1;
                else                               wait_d        = wait_q + 1'b1;
            end

            ST_SCROLL_WR: begin
                if (idx_q == IDX_W'(COPY_LAST)) begin
                    state_d  = ST_SCROLL_CLR;
                    idx_d    = '0;
                    cur_cmd  = CUR_LAST_ROW;
                    wready_d = 1'b1;
                    waddr_d  = LAST_ROW_BASE;
                    wbyte_d  = CH_SPACE;
                end else begin
                    state_d = ST_SCROLL_RD;
                    idx_d   = idx_q + 1'b1;
                    rreq_d  = 1'b1;
                    raddr_d = BUF_BASE + AW'(COLS) + AW'(idx_q) + 1'b1;
                end
            end

            ST_SCROLL_CLR: begin
                if (idx_q == IDX_W'(COLS - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d    = idx_q + 1'b1;
                    wready_d = 1'b1;
                    waddr_d  = LAST_ROW_BASE + AW'(idx_q) + 1'b1;
                end
            end

            ST_CLEAR: begin
                if (idx_q == IDX_W'(CLEAR_LAST)) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d    = idx_q + 1'b1;
                    wready_d = 1'b1;
                    waddr_d  = BUF_BASE + AW'(idx_q) + 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (start_scroll) begin
            state_d = ST_SCROLL_RD;
            idx_d   = '0;
            rreq_d  = 1'b1;
            raddr_d = BUF_BASE + AW'(COLS);
        end

        if (start_copy_wr) begin
            state_d  = ST_SCROLL_WR;
            wready_d = 1'b1;
            copy_d   = 1'b1;
            waddr_d  = BUF_BASE + AW'(idx_q);
        end

        ready_d = started_q && (state_d == ST_IDLE);
        busy_d  = state_d inside {ST_SCROLL_RD, ST_SCROLL_WAIT, ST_SCROLL_WR,
                                  ST_SCROLL_CLR, ST_CLEAR};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            wait_q    <= '0;
            pend_q    <= 1'b0;
            started_q <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            wready_q  <= 1'b0;
            rreq_q    <= 1'b0;
            copy_q    <= 1'b0;
            waddr_q   <= '0;
            raddr_q   <= '0;
            wbyte_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so they all update together at the edge.
            state_q   <= state_d;
            idx_q     <= idx_d;
            wait_q    <= wait_d;
            pend_q    <= pend_d;
            started_q <= 1'b1;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            wready_q  <= wready_d;
            rreq_q    <= rreq_d;
            copy_q    <= copy_d;
            waddr_q   <= waddr_d;
            raddr_q   <= raddr_d;
            wbyte_q   <= wbyte_d;
            wstrb_q   <= started_q ? 4'b0001 : 4'b0000;
        end
    end

    // Copy writes forward the read data in the cycle it arrives; that keeps a
    // tile copy at RD_LAT+1 cycles without ever overlapping read and write.
    assign bus.axil_wdata_o  = {{(C_AXI_DATA_WIDTH-8){1'b0}},
                                copy_q ? bus.axil_rdata_i[7:0] : wbyte_q};
    assign bus.axil_wstrb_o  = wstrb_q;
    assign bus.axil_waddr_o  = waddr_q;
    assign bus.axil_wready_o = wready_q;
    assign bus.axil_rreq_o   = rreq_q;
    assign bus.axil_raddr_o  = raddr_q;

    assign char_ready_o = ready_q;
    assign busy_o       = busy_q;
    assign cursor_col_o = cur_col;
    assign cursor_row_o = cur_row;

    assign unused_rdata = ^bus.axil_rdata_i[C_AXI_DATA_WIDTH-1:8];

endmodule

// File: tb/tb_vga_text_console.sv
// Directed bench for vga_text_console against a behavioural vga_top buffer
// with one cycle of read latency.
module tb_vga_text_console;
    import vga_pkg::*;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [7:0] char_i;
    logic       char_valid_i;
    logic       char_ready;
    logic [6:0] col;
    logic [4:0] row;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int both_cnt = 0;

    logic [7:0]  mem [0:8191];
    logic        pre_en;
    logic [12:0] pre_addr;
    logic [7:0]  pre_data;

    vga_text_console_if bus ();

    vga_text_console #(.RD_LAT(1)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .char_i       (char_i),
        .char_valid_i (char_valid_i),
        .char_ready_o (char_ready),
        .bus          (bus),
        .cursor_col_o (col),
        .cursor_row_o (row),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.axil_wready_o) mem[bus.axil_waddr_o] <= bus.axil_wdata_o[7:0];
        else if (pre_en)       mem[pre_addr] <= pre_data;
        if (bus.axil_rreq_o)   bus.axil_rdata_i <= {24'h0, mem[bus.axil_raddr_o]};
    end

    always @(negedge clk) if (bus.axil_wready_o && bus.axil_rreq_o) both_cnt++;

    typedef struct {
        logic [7:0]  ch;
        logic        wr;
        logic [12:0] addr;
        logic [7:0]  data;
        logic [4:0]  row;
        logic [6:0]  col;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] c);
        int guard = 0;
        while (!char_ready && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (!char_ready) check("ready_timeout", {31'b0, char_ready}, 32'd1);
        char_i       = c;
        char_valid_i = 1'b1;
        @(negedge clk);
        char_valid_i = 1'b0;
    endtask

    task automatic wait_busy(output int cyc, output int wr, output int rd,
                             output int addr_err, output int data_err);
        cyc = 0; wr = 0; rd = 0; addr_err = 0; data_err = 0;
        while (busy && cyc < 20000) begin
            if (bus.axil_wready_o) begin
                if (bus.axil_waddr_o !== VGA_BUF_BASE + 13'(wr)) addr_err++;
                if (bus.axil_wdata_o !== 32'h20) data_err++;
                wr++;
            end
            if (bus.axil_rreq_o) rd++;
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc, wr, rd, aerr, derr, bad, stray;

        vecs[0]  = '{8'h41, 1'b1, 13'h1000, 8'h41, 5'd0, 7'd1};
        vecs[1]  = '{8'h0D, 1'b0, 13'h0000, 8'h00, 5'd0, 7'd0};
        vecs[2]  = '{8'h48, 1'b1, 13'h1000, 8'h48, 5'd0, 7'd1};
        vecs[3]  = '{8'h49, 1'b1, 13'h1001, 8'h49, 5'd0, 7'd2};
        vecs[4]  = '{8'h0D, 1'b0, 13'h0000, 8'h00, 5'd0, 7'd0};
        vecs[5]  = '{8'h58, 1'b1, 13'h1000, 8'h58, 5'd0, 7'd1};
        vecs[6]  = '{8'h0A, 1'b0, 13'h0000, 8'h00, 5'd1, 7'd0};
        vecs[7]  = '{8'h5A, 1'b1, 13'h1050, 8'h5A, 5'd1, 7'd1};
        vecs[8]  = '{8'h08, 1'b1, 13'h1050, 8'h20, 5'd1, 7'd0};
        vecs[9]  = '{8'h08, 1'b0, 13'h0000, 8'h00, 5'd1, 7'd0};
        vecs[10] = '{8'h07, 1'b0, 13'h0000, 8'h00, 5'd1, 7'd0};
        vecs[11] = '{8'hFF, 1'b1, 13'h1050, 8'hFF, 5'd1, 7'd1};
        vecs[12] = '{8'h7E, 1'b1, 13'h1051, 8'h7E, 5'd1, 7'd2};
        vecs[13] = '{8'h0D, 1'b0, 13'h0000, 8'h00, 5'd1, 7'd0};

        rst_i = 1'b1; char_i = 8'h51; char_valid_i = 1'b1;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        repeat (3) @(negedge clk);
        check("rst_ready",  {31'b0, char_ready}, 32'd0);
        check("rst_wready", {31'b0, bus.axil_wready_o}, 32'd0);
        check("rst_rreq",   {31'b0, bus.axil_rreq_o}, 32'd0);
        check("rst_wstrb",  {28'b0, bus.axil_wstrb_o}, 32'd0);
        check("rst_busy",   {31'b0, busy}, 32'd0);
        check("rst_cursor", {20'b0, row, col}, 32'd0);
        rst_i = 1'b0; char_valid_i = 1'b0;
        @(negedge clk);
        check("rel1_ready", {31'b0, char_ready}, 32'd0);
        check("rel1_wstrb", {28'b0, bus.axil_wstrb_o}, 32'd0);
        @(negedge clk);
        check("rel2_ready", {31'b0, char_ready}, 32'd1);
        check("rel2_wstrb", {28'b0, bus.axil_wstrb_o}, 32'd1);
        check("rel2_cursor", {20'b0, row, col}, 32'd0);

        for (int i = 0; i < 14; i++) begin
            send_byte(vecs[i].ch);
            check($sformatf("v%0d_wready", i), {31'b0, bus.axil_wready_o}, {31'b0, vecs[i].wr});
            check($sformatf("v%0d_ready", i), {31'b0, char_ready}, {31'b0, !vecs[i].wr});
            if (vecs[i].wr) begin
                check($sformatf("v%0d_waddr", i), {19'b0, bus.axil_waddr_o}, {19'b0, vecs[i].addr});
                check($sformatf("v%0d_wdata", i), bus.axil_wdata_o, {24'b0, vecs[i].data});
                check($sformatf("v%0d_wstrb", i), {28'b0, bus.axil_wstrb_o}, 32'd1);
            end
            check($sformatf("v%0d_row", i), {27'b0, row}, {27'b0, vecs[i].row});
            check($sformatf("v%0d_col", i), {25'b0, col}, {25'b0, vecs[i].col});
        end
        check("mem_1000", {24'b0, mem[13'h1000]}, 32'h58);
        check("mem_1001", {24'b0, mem[13'h1001]}, 32'h49);

        send_byte(CH_FF);
        wait_busy(cyc, wr, rd, aerr, derr);
        check("clr_cycles", cyc, 2400);
        check("clr_writes", wr, 2400);
        check("clr_addr_err", aerr, 0);
        check("clr_data_err", derr, 0);
        check("clr_cursor", {20'b0, row, col}, 32'd0);
        check("clr_ready", {31'b0, char_ready}, 32'd1);

        for (int k = 0; k < 79; k++) send_byte(CH_SPACE);
        send_byte(8'h43);
        check("c79_waddr", {19'b0, bus.axil_waddr_o}, 32'd4175);
        check("c79_wdata", bus.axil_wdata_o, 32'h43);
        check("c79_cursor", {20'b0, row, col}, {20'b0, 5'd1, 7'd0});
        send_byte(CH_BS);
        check("bs0_wready", {31'b0, bus.axil_wready_o}, 32'd0);
        check("bs0_cursor", {20'b0, row, col}, {20'b0, 5'd1, 7'd0});

        for (int k = 0; k < 28; k++) send_byte(CH_LF);
        check("lf28_cursor", {20'b0, row, col}, {20'b0, 5'd29, 7'd0});
        for (int k = 0; k < 80; k++) begin
            pre_en = 1'b1; pre_addr = 13'h1050 + 13'(k); pre_data = 8'h42;
            @(negedge clk);
        end
        pre_en = 1'b0;

        send_byte(CH_LF);
        check("scr_rreq",  {31'b0, bus.axil_rreq_o}, 32'd1);
        check("scr_raddr", {19'b0, bus.axil_raddr_o}, 32'h1050);
        check("scr_ready", {31'b0, char_ready}, 32'd0);
        wait_busy(cyc, wr, rd, aerr, derr);
        check("scr_cycles", cyc, 4720);
        check("scr_writes", wr, 2400);
        check("scr_reads", rd, 2320);
        bad = 0;
        for (int k = 0; k < 80; k++) if (mem[VGA_BUF_BASE + 13'(k)] !== 8'h42) bad++;
        check("scr_row0_B", bad, 0);
        bad = 0;
        for (int k = 0; k < 80; k++) if (mem[13'd6416 + 13'(k)] !== 8'h20) bad++;
        check("scr_row29_blank", bad, 0);
        check("scr_cursor", {20'b0, row, col}, {20'b0, 5'd29, 7'd0});
        check("scr_ready_after", {31'b0, char_ready}, 32'd1);

        for (int k = 0; k < 79; k++) send_byte(8'h78);
        send_byte(8'h79);
        check("wrap_waddr", {19'b0, bus.axil_waddr_o}, 32'd6495);
        check("wrap_wdata", bus.axil_wdata_o, 32'h79);
        check("wrap_cursor", {20'b0, row, col}, {20'b0, 5'd29, 7'd0});
        check("wrap_busy_write", {31'b0, busy}, 32'd0);
        @(negedge clk);
        wait_busy(cyc, wr, rd, aerr, derr);
        check("wrap_scr_cycles", cyc, 4720);
        check("wrap_row28_last", {24'b0, mem[13'd6415]}, 32'h79);
        check("wrap_row28_first", {24'b0, mem[13'd6336]}, 32'h78);
        check("wrap_last_tile", {24'b0, mem[13'd6495]}, 32'h20);

        send_byte(CH_FF);
        repeat (100) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        check("mid_rst_wready", {31'b0, bus.axil_wready_o}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_cursor", {20'b0, row, col}, 32'd0);
        stray = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.axil_wready_o || bus.axil_rreq_o) stray++;
        end
        check("mid_rst_stray", stray, 0);
        rst_i = 1'b0;
        @(negedge clk);
        check("mid_rel1_ready", {31'b0, char_ready}, 32'd0);
        @(negedge clk);
        check("mid_rel2_ready", {31'b0, char_ready}, 32'd1);
        check("mid_rel2_wready", {31'b0, bus.axil_wready_o}, 32'd0);

        check("wready_rreq_exclusive", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
